// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: controller state encoding and register-address constants.
package pipeline_pkg;

    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the ID instruction and a load in EX.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic              uses_rs1,
    input  logic              uses_rs2,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              mem_read,
    output logic              lu_c
);

    logic rs1_match;
    logic rs2_match;

    // A source only matters if the instruction really reads it; x0 never carries a hazard.
    always_comb begin
        rs1_match = uses_rs1 && (rs1_addr == rd_addr);
        rs2_match = uses_rs2 && (rs2_addr == rd_addr);
        lu_c      = mem_read && (rd_addr != REG_ZERO) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: memory-wait freezes, branch flushes, load-use bubbles,
// stall counters and a sticky memory-timeout flag.
module hazard_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_IFID_rs1_addr,
    input  logic [ADDR_W-1:0] i_IFID_rs2_addr,
    input  logic              i_IFID_uses_rs1,
    input  logic              i_IFID_uses_rs2,
    input  logic [ADDR_W-1:0] i_IDEX_rd_addr,
    input  logic              i_IDEX_memRead,
    input  logic              i_EXMEM_memAccess,
    input  logic              i_d_valid_data,
    input  logic              i_branch_taken,
    output logic              o_pc_write,
    output logic              o_IFID_write,
    output logic              o_IDEX_write,
    output logic              o_EXMEM_write,
    output logic              o_MEMWB_bubble,
    output logic              o_IDEX_bubble,
    output logic              o_IFID_flush,
    output logic              o_IDEX_flush,
    output logic [CNT_W-1:0]  o_lu_stalls,
    output logic [CNT_W-1:0]  o_mem_stalls,
    output logic              o_mem_timeout
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic              lu;
    logic              mw;
    logic              freeze;
    logic [WAIT_W-1:0] wait_cnt;

    load_use_detect u_lu (
        .rs1_addr (i_IFID_rs1_addr),
        .rs2_addr (i_IFID_rs2_addr),
        .uses_rs1 (i_IFID_uses_rs1),
        .uses_rs2 (i_IFID_uses_rs2),
        .rd_addr  (i_IDEX_rd_addr),
        .mem_read (i_IDEX_memRead),
        .lu_c     (lu)
    );

    assign mw = i_EXMEM_memAccess && !i_d_valid_data;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and Mealy decode; freeze outranks flush, which outranks load-use.
    always_comb begin
        state_next     = state;
        freeze         = 1'b0;
        o_pc_write     = 1'b1;
        o_IFID_write   = 1'b1;
        o_IDEX_write   = 1'b1;
        o_EXMEM_write  = 1'b1;
        o_MEMWB_bubble = 1'b0;
        o_IDEX_bubble  = 1'b0;
        o_IFID_flush   = 1'b0;
        o_IDEX_flush   = 1'b0;

        unique case (state)
            RUN: begin
                freeze = mw;
                if (mw) begin
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                freeze = !i_d_valid_data;
                if (i_d_valid_data) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase

        if (i_rst) begin
            freeze        = 1'b0;
            o_pc_write    = 1'b0;
            o_IFID_write  = 1'b0;
            o_IDEX_write  = 1'b0;
            o_EXMEM_write = 1'b0;
        end else if (freeze) begin
            o_pc_write     = 1'b0;
            o_IFID_write   = 1'b0;
            o_IDEX_write   = 1'b0;
            o_EXMEM_write  = 1'b0;
            o_MEMWB_bubble = 1'b1;
        end else if (i_branch_taken) begin
            o_IFID_flush = 1'b1;
            o_IDEX_flush = 1'b1;
        end else if (lu) begin
            o_pc_write    = 1'b0;
            o_IFID_write  = 1'b0;
            o_IDEX_bubble = 1'b1;
        end
    end

    // Stall performance counters, wrapping naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_lu_stalls  <= '0;
            o_mem_stalls <= '0;
        end else begin
            if (o_IDEX_bubble) begin
                o_lu_stalls <= o_lu_stalls + CNT_W'(1);
            end
            if (freeze) begin
                o_mem_stalls <= o_mem_stalls + CNT_W'(1);
            end
        end
    end

    // Wait-length tracking; the count saturates so the sticky flag never depends on wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt      <= '0;
            o_mem_timeout <= 1'b0;
        end else if (freeze) begin
            if (wait_cnt < WAIT_MAX) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (wait_cnt >= WAIT_LAST) begin
                o_mem_timeout <= 1'b1;
            end
        end else if (state_next == RUN) begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with an expected-output queue and counter model.
module tb_hazard_stall_ctrl;

    localparam int unsigned CNT_W = 32;

    localparam logic [7:0] C_DEF = 8'b1111_0000;
    localparam logic [7:0] C_FRZ = 8'b0000_1000;
    localparam logic [7:0] C_FLU = 8'b1111_0011;
    localparam logic [7:0] C_LU  = 8'b0011_0100;
    localparam logic [7:0] C_RST = 8'b0000_0000;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       ma;
        logic       v;
        logic       br;
    } stim_t;

    logic             clk;
    logic             rst;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic             uses_rs1;
    logic             uses_rs2;
    logic [4:0]       rd_addr;
    logic             mem_read;
    logic             mem_access;
    logic             d_valid;
    logic             branch_taken;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             memwb_bubble;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             idex_flush;
    logic [CNT_W-1:0] lu_stalls;
    logic [CNT_W-1:0] mem_stalls;
    logic             mem_timeout;

    logic [7:0] exp_q[$];
    int         total;
    int         bad;
    int         exp_lu;
    int         exp_mem;

    hazard_stall_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (4)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_IFID_rs1_addr   (rs1_addr),
        .i_IFID_rs2_addr   (rs2_addr),
        .i_IFID_uses_rs1   (uses_rs1),
        .i_IFID_uses_rs2   (uses_rs2),
        .i_IDEX_rd_addr    (rd_addr),
        .i_IDEX_memRead    (mem_read),
        .i_EXMEM_memAccess (mem_access),
        .i_d_valid_data    (d_valid),
        .i_branch_taken    (branch_taken),
        .o_pc_write        (pc_write),
        .o_IFID_write      (ifid_write),
        .o_IDEX_write      (idex_write),
        .o_EXMEM_write     (exmem_write),
        .o_MEMWB_bubble    (memwb_bubble),
        .o_IDEX_bubble     (idex_bubble),
        .o_IFID_flush      (ifid_flush),
        .o_IDEX_flush      (idex_flush),
        .o_lu_stalls       (lu_stalls),
        .o_mem_stalls      (mem_stalls),
        .o_mem_timeout     (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                                 input logic a1, input logic a2, input logic [4:0] d,
                                 input logic m, input logic acc, input logic val,
                                 input logic b);
        stim_t s;
        s.rst = r; s.rs1 = s1; s.rs2 = s2; s.u1 = a1; s.u2 = a2;
        s.rd = d; s.mr = m; s.ma = acc; s.v = val; s.br = b;
        return s;
    endfunction

    // Drive one cycle, check the same-cycle controls, then the registered state after the edge.
    task automatic step(input string tag, input stim_t s, input logic [7:0] e, input logic e_to);
        logic [7:0] want;
        logic [7:0] got;
        rst = s.rst; rs1_addr = s.rs1; rs2_addr = s.rs2; uses_rs1 = s.u1; uses_rs2 = s.u2;
        rd_addr = s.rd; mem_read = s.mr; mem_access = s.ma; d_valid = s.v; branch_taken = s.br;
        exp_q.push_back(e);
        #4;
        want = exp_q.pop_front();
        got  = {pc_write, ifid_write, idex_write, exmem_write,
                memwb_bubble, idex_bubble, ifid_flush, idex_flush};
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, got, want);
        end
        if (s.rst) begin
            exp_lu  = 0;
            exp_mem = 0;
        end else begin
            if (want[2]) exp_lu++;
            if (want == C_FRZ) exp_mem++;
        end
        @(posedge clk);
        #1;
        total++;
        assert (lu_stalls === CNT_W'(exp_lu)) else begin
            bad++;
            $error("FAIL %s lu_stalls observed=%0d expected=%0d", tag, lu_stalls, exp_lu);
        end
        total++;
        assert (mem_stalls === CNT_W'(exp_mem)) else begin
            bad++;
            $error("FAIL %s mem_stalls observed=%0d expected=%0d", tag, mem_stalls, exp_mem);
        end
        total++;
        assert (mem_timeout === e_to) else begin
            bad++;
            $error("FAIL %s timeout observed=%b expected=%b", tag, mem_timeout, e_to);
        end
    endtask

    initial begin
        total = 0; bad = 0; exp_lu = 0; exp_mem = 0;
        rst = 1'b1; rs1_addr = '0; rs2_addr = '0; uses_rs1 = 1'b0; uses_rs2 = 1'b0;
        rd_addr = '0; mem_read = 1'b0; mem_access = 1'b0; d_valid = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;

        step("reset",     mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_RST, 1'b0);
        step("idle",      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_DEF, 1'b0);

        step("lu_rs1",    mk(0, 5, 0, 1, 0, 5, 1, 0, 1, 0), C_LU,  1'b0);
        step("lu_after",  mk(0, 5, 0, 1, 0, 5, 0, 0, 1, 0), C_DEF, 1'b0);
        step("x0_rd",     mk(0, 0, 0, 1, 0, 0, 1, 0, 1, 0), C_DEF, 1'b0);
        step("rs2_unused",mk(0, 0, 7, 0, 0, 7, 1, 0, 1, 0), C_DEF, 1'b0);
        step("lu_rs2",    mk(0, 0, 7, 0, 1, 7, 1, 0, 1, 0), C_LU,  1'b0);

        step("mw_1",      mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_FRZ, 1'b0);
        step("mw_2",      mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_FRZ, 1'b0);
        step("mw_3",      mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_FRZ, 1'b0);
        step("mw_rel",    mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), C_DEF, 1'b0);
        step("mw_in_run", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_DEF, 1'b0);

        step("prio_frz",  mk(0, 3, 0, 1, 0, 3, 1, 1, 0, 1), C_FRZ, 1'b0);
        step("prio_flu",  mk(0, 3, 0, 1, 0, 3, 1, 1, 1, 1), C_FLU, 1'b0);
        step("flu_lu",    mk(0, 3, 0, 1, 0, 3, 1, 0, 0, 1), C_FLU, 1'b0);
        step("prio_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_DEF, 1'b0);

        step("to_1",      mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_FRZ, 1'b0);
        step("to_2",      mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_FRZ, 1'b0);
        step("to_3",      mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_FRZ, 1'b0);
        step("to_4",      mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_FRZ, 1'b1);
        step("to_5",      mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_FRZ, 1'b1);
        step("to_6",      mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_FRZ, 1'b1);
        step("to_rel",    mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), C_DEF, 1'b1);
        step("to_hold",   mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_DEF, 1'b1);

        step("rw_enter",  mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_FRZ, 1'b1);
        step("rw_rst",    mk(1, 5, 0, 1, 0, 5, 1, 1, 0, 1), C_RST, 1'b0);
        step("rw_run",    mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_DEF, 1'b0);
        step("rw_lu",     mk(0, 9, 0, 1, 0, 9, 1, 0, 0, 0), C_LU,  1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
